// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the write-request record for the register-file write arbiter
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wr_req_t;
endpackage

// File: rtl/regfile_wr_fifo.sv
// regfile_wr_fifo: synchronous buffer of long-latency write requests, extra pointer bit separates full from empty
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  wr_req_t push_req,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wr_req_t head
);
  localparam int AW = $clog2(FIFO_DEPTH);
  wr_req_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clock)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_req;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between pipeline writeback and buffered long-latency results.
// Optional pending-write scoreboard enabled by REGFILE_SCOREBOARD_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  stall_wb,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  input  logic [REG_ADDR_W-1:0] query_rs1,
  input  logic [REG_ADDR_W-1:0] query_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_addr_rd,
  output logic [XLEN-1:0]       rf_data_rd
);
  logic full, empty, forced, fifo_grant, wb_grant, push;
  logic [3:0] starve;
  wr_req_t head, sel;
  assign lu_ready = !reset && !full;
  assign push = lu_valid && lu_ready && lu_rd != '0;
  regfile_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .push_req('{rd: lu_rd, data: lu_data}),
    .pop(fifo_grant), .full(full), .empty(empty), .head(head)
  );
  always_comb begin
    forced = !reset && !empty && starve == 4'(STARVE_LIMIT);
    fifo_grant = forced || (!reset && !wb_valid && !empty);
    wb_grant = !reset && wb_valid && !forced;
    stall_wb = forced && wb_valid;
    sel = fifo_grant ? head : '{rd: wb_rd, data: wb_data};
    rf_write_enable = (fifo_grant || wb_grant) && sel.rd != '0;
    rf_addr_rd = sel.rd;
    rf_data_rd = sel.data;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) starve <= '0;
    else if (empty || fifo_grant) starve <= '0;
    else if (starve != 4'(STARVE_LIMIT)) starve <= starve + 4'd1;
`ifdef REGFILE_SCOREBOARD_EN
  logic [XLEN-1:0] pending;
  // a new issue to a register outranks the retiring write of its older result
  always_ff @(posedge clock or posedge reset)
    if (reset) pending <= '0;
    else pending <= (pending & ~(fifo_grant ? XLEN'(1) << head.rd : '0))
                  | (lu_issue && lu_issue_rd != '0 ? XLEN'(1) << lu_issue_rd : '0);
  assign busy_rs1 = pending[query_rs1];
  assign busy_rs2 = pending[query_rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{lu_issue, lu_issue_rd, query_rs1, query_rs2};
  assign busy_rs1 = 1'b0;
  assign busy_rs2 = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with a queued scoreboard of expected register-file writes
module tb_regfile_write_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic wb_valid = 0, lu_valid = 0, lu_issue = 0;
  logic [4:0] wb_rd = 0, lu_rd = 0, lu_issue_rd = 0, query_rs1 = 0, query_rs2 = 0;
  logic [31:0] wb_data = 0, lu_data = 0;
  logic stall_wb, lu_ready, busy_rs1, busy_rs2, rf_write_enable;
  logic [4:0] rf_addr_rd;
  logic [31:0] rf_data_rd;
  int n_tot = 0, n_pass = 0;
  logic [37:0] exp_q [$];
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_wb(stall_wb), .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .query_rs1(query_rs1), .query_rs2(query_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .rf_write_enable(rf_write_enable),
    .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic stall, input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({stall, rd, data});
  endtask

  // every write strobe or stall must match the oldest outstanding expectation
  always @(negedge clock)
    if (rf_write_enable || stall_wb) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_write got stall=%b rd=%0d data=%h expected no write", stall_wb, rf_addr_rd, rf_data_rd);
      end else chk("write", {26'd0, stall_wb, rf_addr_rd, rf_data_rd}, {26'd0, exp_q.pop_front()});
    end

  initial begin
    logic [6:0] rdy_tab;
    int idx;
    rdy_tab = 7'b1000011;
    wb_valid = 1; wb_rd = 4; wb_data = 32'h4444;
    #2;
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_wen", rf_write_enable, 0);
    chk("rst_stall", stall_wb, 0);
    step();
    wb_valid = 0;
    reset = 0;
    #1;
    chk("rel_lu_ready", lu_ready, 1);
    // writeback with idle FIFO is written the same cycle
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    expect_wr(0, 5, 32'hDEADBEEF);
    step();
    wb_valid = 0;
    // single long-latency result lands one cycle after acceptance
    lu_valid = 1; lu_rd = 7; lu_data = 32'h12;
    chk("lu7_ready", lu_ready, 1);
    step();
    lu_valid = 0;
    expect_wr(0, 7, 32'h12);
    step();
    step();
    // result to r0 handshakes but never writes
    lu_valid = 1; lu_rd = 0; lu_data = 32'h55;
    chk("lu0_ready", lu_ready, 1);
    step();
    lu_valid = 0;
    step();
    step();
    chk("lu0_ready_after", lu_ready, 1);
    // back-to-back results against continuous writeback: fill, starve, forced grant
    idx = 0;
    lu_valid = 1;
    for (int c = 0; c < 7; c++) begin
      lu_rd = 5'(10 + idx); lu_data = 32'hA0 + 32'(16 * idx);
      wb_valid = 1; wb_rd = 1; wb_data = 32'h100 + 32'(c);
      chk($sformatf("starve_ready_c%0d", c), lu_ready, rdy_tab[c]);
      if (c == 5) expect_wr(1, 10, 32'hA0);
      else expect_wr(0, 1, 32'h100 + 32'(c));
      step();
      if (rdy_tab[c]) idx++;
    end
    lu_valid = 0; wb_valid = 0;
    expect_wr(0, 11, 32'hB0);
    expect_wr(0, 12, 32'hC0);
    step();
    step();
    step();
    // pending-write scoreboard
    lu_issue = 1; lu_issue_rd = 9; query_rs1 = 9; query_rs2 = 3;
    chk("busy_pre", busy_rs1, 0);
    step();
    lu_issue = 0;
    chk("busy_issued", busy_rs1, SB);
    chk("busy_rs2_other", busy_rs2, 0);
    wb_valid = 1; wb_rd = 2; wb_data = 32'h222;
    expect_wr(0, 2, 32'h222);
    lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
    step();
    lu_valid = 0; wb_valid = 0;
    chk("busy_buffered", busy_rs1, SB);
    lu_issue = 1; lu_issue_rd = 9;
    expect_wr(0, 9, 32'h99);
    step();
    lu_issue = 0;
    chk("busy_set_wins", busy_rs1, SB);
    lu_valid = 1; lu_rd = 9; lu_data = 32'h9A;
    step();
    lu_valid = 0;
    chk("busy_before_clear", busy_rs1, SB);
    expect_wr(0, 9, 32'h9A);
    step();
    chk("busy_cleared", busy_rs1, 0);
    // reset while two results are buffered discards them
    wb_valid = 1; wb_rd = 3; wb_data = 32'h333;
    lu_valid = 1; lu_rd = 20; lu_data = 32'h1;
    expect_wr(0, 3, 32'h333);
    step();
    lu_rd = 21; lu_data = 32'h2; wb_data = 32'h334;
    expect_wr(0, 3, 32'h334);
    step();
    chk("full_before_reset", lu_ready, 0);
    lu_valid = 0; wb_valid = 0;
    reset = 1;
    #1;
    chk("midrst_lu_ready", lu_ready, 0);
    chk("midrst_wen", rf_write_enable, 0);
    step();
    step();
    reset = 0;
    #1;
    chk("post_rst_ready", lu_ready, 1);
    step();
    step();
    step();
    chk("sb_drain", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
